// File: rtl/ahb5_sram_subordinate.sv
// AHB5 SRAM subordinate: byte-addressable little-endian memory with pipelined
// address/data phases, fixed wait states and a two-cycle ERROR response.
module ahb5_sram_subordinate #(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned HBURST_WIDTH = 3,
   parameter int unsigned MEM_DEPTH    = 256,
   parameter int unsigned WAIT_STATES  = 0
) (
   input  logic                    HCLK,
   input  logic                    HRESETn,
   input  logic                    HSEL,
   input  logic                    HREADY,
   input  logic [ADDR_WIDTH-1:0]   HADDR,
   input  logic [1:0]              HTRANS,
   input  logic [2:0]              HSIZE,
   input  logic [HBURST_WIDTH-1:0] HBURST,
   input  logic                    HWRITE,
   input  logic [DATA_WIDTH-1:0]   HWDATA,
   input  logic [DATA_WIDTH/8-1:0] HWSTRB,
   output logic [DATA_WIDTH-1:0]   HRDATA,
   output logic                    HREADYOUT,
   output logic                    HRESP
);

   localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
   localparam int unsigned LANE_BITS = $clog2(NUM_LANES);
   localparam int unsigned MEM_AW    = $clog2(MEM_DEPTH);

   typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;

   state_t              state_q, state_d;
   logic [2:0]          wait_cnt_q, wait_cnt_d;
   logic [MEM_AW-1:0]   addr_q;
   logic [2:0]          size_q;
   logic                write_q;
   logic                err_q;

   logic                accept;
   logic                size_err, align_err, range_err, addr_err;
   logic [NUM_LANES-1:0] lane_act;
   logic [MEM_AW-1:0]   word_base;
   logic                wr_en;
   logic                unused_ok;

   logic [7:0] mem [MEM_DEPTH];

   assign unused_ok = ^{HBURST, HTRANS[0]};

   assign HREADYOUT = !(state_q == ST_WAIT || state_q == ST_ERR1);
   assign HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2);

   assign accept    = HSEL && HREADY && HTRANS[1] && HREADYOUT;

   assign size_err  = (32'd8 << HSIZE) > DATA_WIDTH;
   assign align_err = |(HADDR & ~({ADDR_WIDTH{1'b1}} << HSIZE));
   // Full address compare so out-of-range accesses never alias onto the array.
   assign range_err = 64'(HADDR) >= 64'(MEM_DEPTH);
   assign addr_err  = size_err || align_err || range_err;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         ST_WAIT: begin
            if (wait_cnt_q == 3'(WAIT_STATES - 1)) begin
               state_d    = ST_DATA;
               wait_cnt_d = '0;
            end else begin
               wait_cnt_d = wait_cnt_q + 3'd1;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: begin
            if (accept) begin
               wait_cnt_d = '0;
               if (addr_err)              state_d = ST_ERR1;
               else if (WAIT_STATES != 0) state_d = ST_WAIT;
               else                       state_d = ST_DATA;
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
         addr_q     <= '0;
         size_q     <= '0;
         write_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if (accept) begin
            addr_q  <= HADDR[MEM_AW-1:0];
            size_q  <= HSIZE;
            write_q <= HWRITE;
            err_q   <= addr_err;
         end
      end
   end

   always_comb begin
      int unsigned lo;
      int unsigned nbytes;
      lane_act  = '0;
      word_base = addr_q & ~MEM_AW'(NUM_LANES - 1);
      lo        = 32'(addr_q[LANE_BITS-1:0]);
      nbytes    = 32'd1 << size_q;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         lane_act[i] = (i >= lo) && (i < lo + nbytes);
      end
   end

   assign wr_en = (state_q == ST_DATA) && write_q && !err_q && HRESETn;

   // Memory contents survive reset.
   always_ff @(posedge HCLK) begin
      if (wr_en) begin
         for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (lane_act[i] && HWSTRB[i]) begin
               mem[word_base | MEM_AW'(i)] <= HWDATA[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      HRDATA = '0;
      if (state_q == ST_DATA && !write_q) begin
         for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (lane_act[i]) HRDATA[8*i +: 8] = mem[word_base | MEM_AW'(i)];
         end
      end
   end

endmodule

// File: tb/tb_ahb5_sram_subordinate.sv
// Table-driven bench: three subordinate configs (32b/0ws, 32b/2ws, 64b/0ws) on a shared bus,
// one selected per vector; each row holds an address phase plus the expected data-phase outputs.
module tb_ahb5_sram_subordinate;

   localparam logic [1:0] IDL = 2'b00;
   localparam logic [1:0] BSY = 2'b01;
   localparam logic [1:0] NSQ = 2'b10;

   logic        HCLK = 1'b0;
   logic        HRESETn = 1'b0;
   logic [2:0]  hsel = '0;
   logic [31:0] haddr = '0;
   logic [1:0]  htrans = IDL;
   logic [2:0]  hsize = '0;
   logic [2:0]  hburst = '0;
   logic        hwrite = 1'b0;
   logic [63:0] hwdata = '0;
   logic [7:0]  hwstrb = '0;

   logic [31:0] rdata0, rdata1;
   logic [63:0] rdata2;
   logic        rdy0, rdy1, rdy2;
   logic        rsp0, rsp1, rsp2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 HCLK = ~HCLK;

   ahb5_sram_subordinate #(.DATA_WIDTH(32), .WAIT_STATES(0)) u_dut0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HREADY(rdy0), .HADDR(haddr),
      .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HWRITE(hwrite),
      .HWDATA(hwdata[31:0]), .HWSTRB(hwstrb[3:0]), .HRDATA(rdata0), .HREADYOUT(rdy0),
      .HRESP(rsp0)
   );

   ahb5_sram_subordinate #(.DATA_WIDTH(32), .WAIT_STATES(2)) u_dut1 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HREADY(rdy1), .HADDR(haddr),
      .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HWRITE(hwrite),
      .HWDATA(hwdata[31:0]), .HWSTRB(hwstrb[3:0]), .HRDATA(rdata1), .HREADYOUT(rdy1),
      .HRESP(rsp1)
   );

   ahb5_sram_subordinate #(.DATA_WIDTH(64), .WAIT_STATES(0)) u_dut2 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[2]), .HREADY(rdy2), .HADDR(haddr),
      .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HWRITE(hwrite),
      .HWDATA(hwdata), .HWSTRB(hwstrb), .HRDATA(rdata2), .HREADYOUT(rdy2),
      .HRESP(rsp2)
   );

   typedef struct {
      int unsigned dut;
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [7:0]  strb;
      logic        rdy;
      logic        rsp;
      logic [63:0] rdata;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input int unsigned dut, input logic sel, input logic [1:0] tr,
                      input logic wr, input logic [2:0] sz, input logic [31:0] a,
                      input logic [63:0] wd, input logic [7:0] st, input logic rdy,
                      input logic rsp, input logic [63:0] rd);
      vec_t v;
      v.dut = dut; v.sel = sel; v.trans = tr; v.wr = wr; v.size = sz; v.addr = a;
      v.wdata = wd; v.strb = st; v.rdy = rdy; v.rsp = rsp; v.rdata = rd;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_dut(input string name, input int unsigned dut, input logic rdy,
                          input logic rsp, input logic [63:0] rd);
      logic        a_rdy, a_rsp;
      logic [63:0] a_rd;
      case (dut)
         0:       begin a_rdy = rdy0; a_rsp = rsp0; a_rd = {32'b0, rdata0}; end
         1:       begin a_rdy = rdy1; a_rsp = rsp1; a_rd = {32'b0, rdata1}; end
         default: begin a_rdy = rdy2; a_rsp = rsp2; a_rd = rdata2; end
      endcase
      chk({name, " HREADYOUT"}, {63'b0, a_rdy}, {63'b0, rdy});
      chk({name, " HRESP"}, {63'b0, a_rsp}, {63'b0, rsp});
      chk({name, " HRDATA"}, a_rd, rd);
   endtask

   task automatic drive(input int unsigned dut, input logic sel, input logic [1:0] tr,
                        input logic wr, input logic [2:0] sz, input logic [31:0] a,
                        input logic [63:0] wd, input logic [7:0] st);
      hsel = '0;
      hsel[dut] = sel;
      htrans = tr; hwrite = wr; hsize = sz; haddr = a; hwdata = wd; hwstrb = st;
   endtask

   initial begin
      // 32-bit, zero wait states
      add(0, 1, NSQ, 1, 2, 'h00, 0, 0, 1, 0, 0);
      add(0, 1, NSQ, 1, 2, 'h10, 'h11223344, 'hF, 1, 0, 0);
      add(0, 1, NSQ, 0, 2, 'h10, 'hA1B2C3D4, 'hF, 1, 0, 0);
      add(0, 1, IDL, 0, 0, 'h00, 0, 0, 1, 0, 'hA1B2C3D4);
      add(0, 1, NSQ, 1, 0, 'h13, 0, 0, 1, 0, 0);
      add(0, 1, NSQ, 0, 2, 'h10, 'hEE000000, 'h8, 1, 0, 0);
      add(0, 1, IDL, 0, 0, 'h00, 0, 0, 1, 0, 'hEEB2C3D4);
      add(0, 1, NSQ, 1, 2, 'h20, 0, 0, 1, 0, 0);
      add(0, 1, NSQ, 1, 2, 'h20, 0, 'hF, 1, 0, 0);
      add(0, 1, NSQ, 0, 2, 'h20, 'hFFFFFFFF, 'h5, 1, 0, 0);
      add(0, 1, IDL, 0, 0, 'h00, 0, 0, 1, 0, 'h00FF00FF);
      add(0, 1, NSQ, 0, 1, 'h12, 0, 0, 1, 0, 0);
      add(0, 1, NSQ, 0, 0, 'h11, 0, 0, 1, 0, 'hEEB20000);
      add(0, 1, BSY, 0, 0, 'h12, 0, 0, 1, 0, 'h0000C300);
      add(0, 1, IDL, 0, 0, 'h00, 0, 0, 1, 0, 0);
      add(0, 0, NSQ, 0, 2, 'h10, 0, 0, 1, 0, 0);
      add(0, 1, IDL, 0, 0, 'h00, 0, 0, 1, 0, 0);
      // error: misaligned + out of range read, then IDLE cancel
      add(0, 1, NSQ, 0, 2, 'h102, 0, 0, 1, 0, 0);
      add(0, 1, IDL, 0, 0, 'h00, 0, 0, 0, 1, 0);
      add(0, 1, IDL, 0, 0, 'h00, 0, 0, 1, 1, 0);
      add(0, 1, IDL, 0, 0, 'h00, 0, 0, 1, 0, 0);
      // error write @0x100 (no alias onto 0x00), misaligned write accepted in ERR2
      add(0, 1, NSQ, 1, 2, 'h100, 0, 0, 1, 0, 0);
      add(0, 1, IDL, 0, 0, 'h00, 'h12345678, 'hF, 0, 1, 0);
      add(0, 1, NSQ, 1, 2, 'h02, 0, 0, 1, 1, 0);
      add(0, 1, IDL, 0, 0, 'h00, 'h55555555, 'hF, 0, 1, 0);
      add(0, 1, NSQ, 0, 2, 'h00, 0, 0, 1, 1, 0);
      add(0, 1, IDL, 0, 0, 'h00, 0, 0, 1, 0, 'h11223344);
      // size wider than the bus
      add(0, 1, NSQ, 0, 3, 'h08, 0, 0, 1, 0, 0);
      add(0, 1, IDL, 0, 0, 'h00, 0, 0, 0, 1, 0);
      add(0, 1, IDL, 0, 0, 'h00, 0, 0, 1, 1, 0);
      add(0, 1, IDL, 0, 0, 'h00, 0, 0, 1, 0, 0);
      // 32-bit, two wait states
      add(1, 1, NSQ, 1, 2, 'h10, 0, 0, 1, 0, 0);
      add(1, 1, NSQ, 0, 2, 'h10, 'hCAFEF00D, 'hF, 0, 0, 0);
      add(1, 1, NSQ, 0, 2, 'h10, 'hCAFEF00D, 'hF, 0, 0, 0);
      add(1, 1, NSQ, 0, 2, 'h10, 'hCAFEF00D, 'hF, 1, 0, 0);
      add(1, 1, IDL, 0, 0, 'h00, 0, 0, 0, 0, 0);
      add(1, 1, IDL, 0, 0, 'h00, 0, 0, 0, 0, 0);
      add(1, 1, IDL, 0, 0, 'h00, 0, 0, 1, 0, 'hCAFEF00D);
      add(1, 1, IDL, 0, 0, 'h00, 0, 0, 1, 0, 0);
      // 64-bit, zero wait states
      add(2, 1, NSQ, 1, 3, 'h08, 0, 0, 1, 0, 0);
      add(2, 1, NSQ, 1, 1, 'h0E, 'h1122334455667788, 'hFF, 1, 0, 0);
      add(2, 1, NSQ, 0, 3, 'h08, 'hBEEF000000000000, 'hC0, 1, 0, 0);
      add(2, 1, NSQ, 0, 2, 'h0C, 0, 0, 1, 0, 'hBEEF334455667788);
      add(2, 1, NSQ, 1, 1, 'h08, 0, 0, 1, 0, 'hBEEF334400000000);
      add(2, 1, NSQ, 0, 3, 'h08, 'hFFFFFFFFFFFFFFFF, 'hFF, 1, 0, 0);
      add(2, 1, IDL, 0, 0, 'h00, 0, 0, 1, 0, 'hBEEF33445566FFFF);
      add(2, 1, IDL, 0, 0, 'h00, 0, 0, 1, 0, 0);

      // Reset held for three cycles; all outputs idle throughout
      for (int c = 0; c < 3; c++) begin
         @(posedge HCLK);
         #1;
         for (int unsigned d = 0; d < 3; d++) chk_dut($sformatf("reset c%0d dut%0d", c, d), d,
                                                      1'b1, 1'b0, 64'h0);
      end
      HRESETn = 1'b1;

      foreach (vecs[i]) begin
         @(posedge HCLK);
         #1;
         drive(vecs[i].dut, vecs[i].sel, vecs[i].trans, vecs[i].wr, vecs[i].size,
               vecs[i].addr, vecs[i].wdata, vecs[i].strb);
         #3;
         chk_dut($sformatf("row%0d", i), vecs[i].dut, vecs[i].rdy, vecs[i].rsp, vecs[i].rdata);
      end

      // Reset during a write data phase must drop the write
      @(posedge HCLK);
      #1;
      drive(0, 1, NSQ, 1, 2, 'h10, 0, 0);
      @(posedge HCLK);
      #1;
      drive(0, 1, IDL, 0, 0, 'h00, 'hDEADBEEF, 'hF);
      #1;
      HRESETn = 1'b0;
      #2;
      chk_dut("midreset", 0, 1'b1, 1'b0, 64'h0);
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      drive(0, 1, NSQ, 0, 2, 'h10, 0, 0);
      @(posedge HCLK);
      #1;
      drive(0, 1, IDL, 0, 0, 'h00, 0, 0);
      #3;
      chk_dut("after midreset read", 0, 1'b1, 1'b0, 64'hEEB2C3D4);

      @(posedge HCLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
